// File: rtl/ipf_window_if.sv
// Handshake bundle for ipf_window_engine: weight beats, input rows and results.
// The master side drives stimulus and consumes results; the slave side is the engine.
interface ipf_window_if #(
    parameter int DW   = 8,
    parameter int NCOL = 8,
    parameter int ACCW = 21
);
    localparam int BW = NCOL * DW;

    logic [BW-1:0]        w_data;
    logic                 w_valid;
    logic                 w_ready;
    logic [BW-1:0]        i_data;
    logic                 i_valid;
    logic                 i_last;
    logic                 i_ready;
    logic [NCOL*ACCW-1:0] res;
    logic                 res_valid;
    logic                 res_ready;

    modport master (
        output w_data, w_valid, i_data, i_valid, i_last, res_ready,
        input  w_ready, i_ready, res, res_valid
    );

    modport slave (
        input  w_data, w_valid, i_data, i_valid, i_last, res_ready,
        output w_ready, i_ready, res, res_valid
    );
endinterface

// File: rtl/ipf_window_engine.sv
// KxK (K=3/5) sliding-window MAC: loads weights, buffers the last K rows and emits one
// row of NCOL circularly wrapped dot products per input row once K rows are held.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for start; ksize latched when start is accepted
//   S_LOADW | accepting weight beats (2 for K=3, 4 for K=5)
//   S_FILL  | accepting the first K rows; row K launches the first result
//   S_RUN   | every accepted row launches a result
//   S_DRAIN | final result launched, waiting for its handshake
//   S_DONE  | one-cycle finish pulse; row count and weights cleared
module ipf_window_engine #(
    parameter int DW   = 8,
    parameter int NCOL = 8,
    parameter int ACCW = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        ksize,
    ipf_window_if.slave bus,
    output logic        busy,
    output logic        finish
);
    localparam int BW  = NCOL * DW;
    localparam int NW  = 25;
    localparam int NR  = 5;
    localparam int WB3 = (9 * DW + BW - 1) / BW;
    localparam int WB5 = (25 * DW + BW - 1) / BW;
    localparam int BCW = $clog2(WB5 + 1);
    localparam logic [BCW-1:0] LAST3 = BCW'(WB3 - 1);
    localparam logic [BCW-1:0] LAST5 = BCW'(WB5 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic                 k5;
    logic [BCW-1:0]       beat_cnt;
    logic [2:0]           row_cnt;
    logic [DW-1:0]        w_q [NW];
    logic [BW-1:0]        rows [NR];
    logic [BW-1:0]        win [NR];
    logic [NCOL*ACCW-1:0] res_nx;
    logic [ACCW-1:0]      acc3;
    logic [ACCW-1:0]      acc5;
    logic                 launch;
    logic                 row_open;
    logic                 w_acc;
    logic                 i_acc;
    logic                 res_take;
    logic [BCW-1:0]       last_beat;
    logic [2:0]           k_val;
    logic                 fill_full;

    assign row_open    = ((state == S_FILL) || (state == S_RUN)) &&
                         (!bus.res_valid || bus.res_ready);
    assign bus.i_ready = row_open;
    assign i_acc       = bus.i_valid && row_open;
    assign w_acc       = bus.w_valid && (state == S_LOADW);
    assign res_take    = bus.res_valid && bus.res_ready;
    assign last_beat   = k5 ? LAST5 : LAST3;
    assign k_val       = k5 ? 3'd5 : 3'd3;
    assign fill_full   = ((row_cnt + 3'd1) == k_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        launch      = 1'b0;
        bus.w_ready = 1'b0;
        busy        = (state != S_IDLE);
        finish      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_LOADW;
            end
            S_LOADW: begin
                bus.w_ready = 1'b1;
                if (bus.w_valid && (beat_cnt == last_beat)) state_nx = S_FILL;
            end
            S_FILL: begin
                if (i_acc) begin
                    if (fill_full) begin
                        launch   = 1'b1;
                        state_nx = bus.i_last ? S_DRAIN : S_RUN;
                    end else if (bus.i_last) begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (i_acc) begin
                    launch = 1'b1;
                    if (bus.i_last) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!bus.res_valid || bus.res_ready) state_nx = S_DONE;
            end
            S_DONE: begin
                finish   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Window as it will look after the accepting edge: incoming row is the newest.
    always_comb begin
        for (int i = 0; i < NR - 1; i++) win[i] = rows[i + 1];
        win[NR-1] = bus.i_data;
    end

    always_comb begin
        res_nx = '0;
        acc3   = '0;
        acc5   = '0;
        for (int c = 0; c < NCOL; c++) begin
            acc3 = '0;
            acc5 = '0;
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    acc3 = acc3 + ACCW'(w_q[r*3+k]) *
                                  ACCW'(win[NR-3+r][((c + k) % NCOL) * DW +: DW]);
                end
            end
            for (int r = 0; r < 5; r++) begin
                for (int k = 0; k < 5; k++) begin
                    acc5 = acc5 + ACCW'(w_q[r*5+k]) *
                                  ACCW'(win[r][((c + k) % NCOL) * DW +: DW]);
                end
            end
            res_nx[c*ACCW +: ACCW] = k5 ? acc5 : acc3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k5            <= 1'b0;
            beat_cnt      <= '0;
            row_cnt       <= '0;
            bus.res       <= '0;
            bus.res_valid <= 1'b0;
            for (int i = 0; i < NW; i++) w_q[i] <= '0;
            for (int i = 0; i < NR; i++) rows[i] <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                k5       <= ksize;
                beat_cnt <= '0;
            end
            // Bytes past the last weight of the chosen K land in unused slots or are dropped.
            if (w_acc) begin
                for (int i = 0; i < NW; i++) begin
                    if (beat_cnt == BCW'(i / NCOL)) w_q[i] <= bus.w_data[(i % NCOL) * DW +: DW];
                end
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (i_acc) begin
                for (int i = 0; i < NR - 1; i++) rows[i] <= rows[i + 1];
                rows[NR-1] <= bus.i_data;
                if (state == S_FILL) row_cnt <= row_cnt + 3'd1;
            end
            if (launch) begin
                bus.res       <= res_nx;
                bus.res_valid <= 1'b1;
            end else if (res_take) begin
                bus.res_valid <= 1'b0;
            end
            if (state == S_DONE) begin
                row_cnt <= '0;
                for (int i = 0; i < NW; i++) w_q[i] <= '0;
            end
        end
    end
endmodule
